tmu2_edgediv: RTL
=================

Name: tmu2_edgediv

Overview:
- Sits directly downstream of the vertex fetch stage in the TMU2 pipeline.
- Receives one square per transaction: four texture-coordinate vertices A, B, C, D, the destination corner drx/dry and the square height.
- Computes the per-scanline step of the left edge (A→C) and right edge (B→D) in X and Y, as sign + quotient + remainder of |difference| / dst_squareh.
- Feeds the edge-walking stage through a stb/ack pipe handshake.

Parameters:
- DIFF_W, 18, magnitude/quotient width (texture coordinate width)
- DIV_W, 11, divisor/remainder width (dst_squareh width)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- busy  out  1  square accepted and not yet handed downstream
- pipe_stb_i  in  1  upstream square valid
- pipe_ack_o  out  1  upstream square accepted this cycle
- ax, ay, bx, by, cx, cy, dx, dy  in  18 each  signed texture coordinates
- drx, dry  in  12 each  signed destination corner
- dst_squareh  in  11  divisor, sampled at accept
- pipe_stb_o  out  1  result valid
- pipe_ack_i  in  1  downstream accepts result
- ax_f, ay_f, bx_f, by_f  out  18 each  registered edge start points (A, B)
- drx_f, dry_f  out  12 each  registered destination corner
- squareh_f  out  11  registered divisor, used for error-term accumulation downstream
- lx_sign, ly_sign, rx_sign, ry_sign  out  1 each  1 = difference negative
- lx_q, ly_q, rx_q, ry_q  out  18 each  quotient
- lx_r, ly_r, rx_r, ry_r  out  11 each  remainder

Behaviour:
- Clock and reset: one clock, sys_clk; reset is synchronous and active-high on sys_rst.
- Reset values: state IDLE; pipe_stb_o=0; busy=0. Data outputs are don't-care but must be deterministic: all 0.
- Edges:
  - lx = cx-ax, ly = cy-ay, rx = dx-bx, ry = dy-by.
  - Each difference is computed at 19 bits signed; sign = bit 18; magnitude = |diff|.
  - Magnitude is ≤ 2^18-1, so it fits in 18 bits unsigned.
- States: IDLE, DIV, OUT.
- IDLE:
  - pipe_ack_o = 1 (combinational). busy = 0.
  - On pipe_stb_i: latch signs, magnitudes, A/B, drx/dry and dst_squareh into registers.
  - Load iteration counter = 17. Go to DIV.
- DIV:
  - busy = 1; pipe_ack_o = 0.
  - Four restoring dividers run in lockstep, one quotient bit per cycle, MSB first.
  - Each cycle: partial remainder (12 bits) = {rem, next dividend bit}. If ≥ divisor, subtract and shift in q bit 1; else shift in 0.
  - After 18 cycles go to OUT.
- OUT:
  - pipe_stb_o = 1; all outputs held stable.
  - On pipe_ack_i, go to IDLE. A new square cannot be accepted in the same cycle.
- Latency: square accepted at cycle T → pipe_stb_o first high at T+19.
- Throughput: at most one square per 20 cycles.
- Divisor zero: dividers bypassed, q=0, r=0, signs still valid. Still goes through DIV for 18 cycles, so latency is unchanged.
- Backpressure: while in OUT with pipe_ack_i=0, every output is frozen and pipe_ack_o=0.
- Reset mid-operation (DIV or OUT): returns to IDLE next cycle, pipe_stb_o drops, the in-flight square is discarded.
- busy is 1 in DIV and OUT. The controller ORs it with the fetch stage busy.

Decomposition:
- Shared package tmu2_pkg:
  - TMU2_COORD_W=18, TMU2_DIM_W=11, TMU2_DST_W=12.
  - State encoding localparams IDLE/DIV/OUT.
- Natural sub-module: tmu2_divider_serial.
  - Restoring DIFF_W/DIV_W divider with start, 18-cycle iteration, zero-divisor bypass, q/r outputs.
  - Instantiated four times; the top holds the FSM, iteration counter, sign logic and pass-through registers.

Test Plan:
- Basic: A=(0,0), C=(100,-50), B=(10,0), D=(10,0), squareh=8 → lx_sign=0 lx_q=12 lx_r=4; ly_sign=1 ly_q=6 ly_r=2; rx/ry q=0 r=0; pipe_stb_o rises exactly 19 cycles after accept.
- Extreme range: ax=-131072, cx=131071, squareh=1 → lx_sign=0, lx_q=262143, lx_r=0. Same pair reversed gives lx_sign=1 with the same magnitude.
- Zero divisor: squareh=0, cx-ax=500 → lx_q=0, lx_r=0, lx_sign=0, latency still 19.
- Backpressure: hold pipe_ack_i=0 for 10 cycles in OUT → outputs unchanged, pipe_ack_o=0, busy=1. Ack → IDLE next cycle, pipe_ack_o=1.
- Back-to-back: pipe_stb_i held high with 3 squares, pipe_ack_i tied 1 → accepts spaced exactly 20 cycles apart; results match a reference model.
- Reset mid-DIV (cycle T+7): pipe_stb_o stays 0, busy=0 after reset. The next square produces correct results with normal latency.

Source files
------------

// File: rtl/tmu2_pkg.sv
// Shared widths and controller state encoding for the TMU2 pipeline stages.
package tmu2_pkg;

    localparam int TMU2_COORD_W = 18;
    localparam int TMU2_DIM_W   = 11;
    localparam int TMU2_DST_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } edgediv_state_e;

endpackage

// File: rtl/tmu2_divider_serial.sv
// Restoring serial divider producing one quotient bit per step, MSB first.
// A zero divisor skips every step so quotient and remainder stay 0.
module tmu2_divider_serial
    import tmu2_pkg::*;
#(
    parameter int DIFF_W = TMU2_COORD_W,
    parameter int DIV_W  = TMU2_DIM_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic [DIFF_W-1:0] dividend_i,
    input  logic [DIV_W-1:0]  divisor_i,
    output logic [DIFF_W-1:0] quotient_o,
    output logic [DIV_W-1:0]  remainder_o
);

    logic [DIFF_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  divisor_q, divisor_d;
    logic              divZero_q, divZero_d;
    logic [DIV_W:0]    partial;

    // shift_q holds the unconsumed dividend bits at the top and the quotient bits at the bottom
    always_comb begin
        shift_d   = shift_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        divZero_d = divZero_q;
        partial   = {rem_q, shift_q[DIFF_W-1]};
        if (start_i) begin
            divZero_d = (divisor_i == '0);
            divisor_d = divisor_i;
            rem_d     = '0;
            shift_d   = divZero_d ? '0 : dividend_i;
        end else if (step_i && !divZero_q) begin
            if (partial >= {1'b0, divisor_q}) begin
                rem_d   = DIV_W'(partial - {1'b0, divisor_q});
                shift_d = {shift_q[DIFF_W-2:0], 1'b1};
            end else begin
                rem_d   = partial[DIV_W-1:0];
                shift_d = {shift_q[DIFF_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            divZero_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            divZero_q <= divZero_d;
        end
    end

    assign quotient_o  = shift_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/tmu2_edgediv.sv
// TMU2 edge divider: per-scanline X/Y steps of the left (A->C) and right (B->D)
// edges as sign, quotient and remainder of |difference| / dst_squareh.
module tmu2_edgediv
    import tmu2_pkg::*;
#(
    parameter int DIFF_W = TMU2_COORD_W,
    parameter int DIV_W  = TMU2_DIM_W
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    output logic                         busy,
    input  logic                         pipe_stb_i,
    output logic                         pipe_ack_o,
    input  logic signed [DIFF_W-1:0]     ax,
    input  logic signed [DIFF_W-1:0]     ay,
    input  logic signed [DIFF_W-1:0]     bx,
    input  logic signed [DIFF_W-1:0]     by,
    input  logic signed [DIFF_W-1:0]     cx,
    input  logic signed [DIFF_W-1:0]     cy,
    input  logic signed [DIFF_W-1:0]     dx,
    input  logic signed [DIFF_W-1:0]     dy,
    input  logic signed [TMU2_DST_W-1:0] drx,
    input  logic signed [TMU2_DST_W-1:0] dry,
    input  logic [DIV_W-1:0]             dst_squareh,
    output logic                         pipe_stb_o,
    input  logic                         pipe_ack_i,
    output logic signed [DIFF_W-1:0]     ax_f,
    output logic signed [DIFF_W-1:0]     ay_f,
    output logic signed [DIFF_W-1:0]     bx_f,
    output logic signed [DIFF_W-1:0]     by_f,
    output logic signed [TMU2_DST_W-1:0] drx_f,
    output logic signed [TMU2_DST_W-1:0] dry_f,
    output logic [DIV_W-1:0]             squareh_f,
    output logic                         lx_sign,
    output logic                         ly_sign,
    output logic                         rx_sign,
    output logic                         ry_sign,
    output logic [DIFF_W-1:0]            lx_q,
    output logic [DIFF_W-1:0]            ly_q,
    output logic [DIFF_W-1:0]            rx_q,
    output logic [DIFF_W-1:0]            ry_q,
    output logic [DIV_W-1:0]             lx_r,
    output logic [DIV_W-1:0]             ly_r,
    output logic [DIV_W-1:0]             rx_r,
    output logic [DIV_W-1:0]             ry_r
);

    localparam int                CNT_W     = $clog2(DIFF_W);
    localparam logic [CNT_W-1:0]  ITER_LAST = CNT_W'(DIFF_W - 1);

    edgediv_state_e   state_q, state_d;
    logic [CNT_W-1:0] iterCnt_q, iterCnt_d;
    logic             accept;
    logic             step;

    logic [DIFF_W-1:0] edgeStart [4];
    logic [DIFF_W-1:0] edgeEnd   [4];
    logic [DIFF_W:0]   edgeDiff  [4];
    logic [DIFF_W-1:0] edgeMag   [4];
    logic [3:0]        edgeNeg;
    logic [DIFF_W-1:0] quot      [4];
    logic [DIV_W-1:0]  remd      [4];

    logic [3:0]                   sign_q;
    logic signed [DIFF_W-1:0]     axF_q, ayF_q, bxF_q, byF_q;
    logic signed [TMU2_DST_W-1:0] drxF_q, dryF_q;
    logic [DIV_W-1:0]             squarehF_q;

    // Edge order: 0 = lx, 1 = ly, 2 = rx, 3 = ry; differences are one bit wider so they cannot overflow
    always_comb begin
        edgeStart[0] = ax;
        edgeStart[1] = ay;
        edgeStart[2] = bx;
        edgeStart[3] = by;
        edgeEnd[0]   = cx;
        edgeEnd[1]   = cy;
        edgeEnd[2]   = dx;
        edgeEnd[3]   = dy;
        edgeNeg      = '0;
        for (int i = 0; i < 4; i++) begin
            edgeDiff[i] = {edgeEnd[i][DIFF_W-1], edgeEnd[i]} - {edgeStart[i][DIFF_W-1], edgeStart[i]};
            edgeNeg[i]  = edgeDiff[i][DIFF_W];
            edgeMag[i]  = edgeNeg[i] ? DIFF_W'(~edgeDiff[i][DIFF_W-1:0] + 1'b1) : edgeDiff[i][DIFF_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        iterCnt_d  = iterCnt_q;
        accept     = 1'b0;
        step       = 1'b0;
        pipe_ack_o = 1'b0;
        pipe_stb_o = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            IDLE: begin
                pipe_ack_o = 1'b1;
                busy       = 1'b0;
                if (pipe_stb_i) begin
                    accept    = 1'b1;
                    iterCnt_d = ITER_LAST;
                    state_d   = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (iterCnt_q == '0) begin
                    state_d = OUT;
                end else begin
                    iterCnt_d = iterCnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                pipe_stb_o = 1'b1;
                if (pipe_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            iterCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iterCnt_q <= iterCnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sign_q     <= '0;
            axF_q      <= '0;
            ayF_q      <= '0;
            bxF_q      <= '0;
            byF_q      <= '0;
            drxF_q     <= '0;
            dryF_q     <= '0;
            squarehF_q <= '0;
        end else if (accept) begin
            sign_q     <= edgeNeg;
            axF_q      <= ax;
            ayF_q      <= ay;
            bxF_q      <= bx;
            byF_q      <= by;
            drxF_q     <= drx;
            dryF_q     <= dry;
            squarehF_q <= dst_squareh;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : gDiv
        tmu2_divider_serial #(
            .DIFF_W (DIFF_W),
            .DIV_W  (DIV_W)
        ) uDiv (
            .clk_i       (sys_clk),
            .rst_i       (sys_rst),
            .start_i     (accept),
            .step_i      (step),
            .dividend_i  (edgeMag[g]),
            .divisor_i   (dst_squareh),
            .quotient_o  (quot[g]),
            .remainder_o (remd[g])
        );
    end

    assign ax_f      = axF_q;
    assign ay_f      = ayF_q;
    assign bx_f      = bxF_q;
    assign by_f      = byF_q;
    assign drx_f     = drxF_q;
    assign dry_f     = dryF_q;
    assign squareh_f = squarehF_q;
    assign lx_sign   = sign_q[0];
    assign ly_sign   = sign_q[1];
    assign rx_sign   = sign_q[2];
    assign ry_sign   = sign_q[3];
    assign lx_q      = quot[0];
    assign ly_q      = quot[1];
    assign rx_q      = quot[2];
    assign ry_q      = quot[3];
    assign lx_r      = remd[0];
    assign ly_r      = remd[1];
    assign rx_r      = remd[2];
    assign ry_r      = remd[3];

endmodule
